// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared control, forwarding and stage types for the pipeline sequencer
package pipe_ctrl_pkg;

    localparam int CPU_REG_ADDR_W = 5;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       is_branch;
        logic       mem_re;
        logic       mem_we;
        logic       reg_wr_en;
        logic       is_mem_to_reg;
    } cpu_ctrl_t;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
    } q3_bits_t;

    localparam int Q3_W = $bits(q3_bits_t);

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                      valid;
        cpu_ctrl_t                 ctrl;
        logic [CPU_REG_ADDR_W-1:0] rd;
        logic [CPU_REG_ADDR_W-1:0] rs1;
        logic [CPU_REG_ADDR_W-1:0] rs2;
    } stage_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational freeze/redirect/load-use detection and EX forwarding selects
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = CPU_REG_ADDR_W
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_redirect,
    input  logic                  mem_ready,
    input  logic                  ex_valid,
    input  logic                  ex_mem_re,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic                  mem_valid,
    input  logic                  mem_re,
    input  logic                  mem_we,
    input  logic                  mem_reg_wr_en,
    input  logic                  mem_is_mem_to_reg,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_reg_wr_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  freeze,
    output logic                  redirect,
    output logic                  load_use,
    output fwd_sel_t              fwd_a,
    output fwd_sel_t              fwd_b
);

    logic mem_src_ok;
    logic wb_src_ok;

    // A load in MEM has no data yet, so only ALU results are forwarded from there.
    assign mem_src_ok = mem_valid & mem_reg_wr_en & ~mem_is_mem_to_reg;
    assign wb_src_ok  = wb_valid & wb_reg_wr_en;

    function automatic fwd_sel_t pick_src(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  m_ok,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  w_ok,
        input logic [REG_ADDR_W-1:0] w_rd
    );
        if (rs == '0)
            return FWD_NONE;
        if (m_ok && m_rd == rs)
            return FWD_MEM;
        if (w_ok && w_rd == rs)
            return FWD_WB;
        return FWD_NONE;
    endfunction

    assign freeze   = mem_valid & (mem_re | mem_we) & ~mem_ready;
    assign redirect = ex_valid & ex_redirect;
    assign load_use = ex_valid & ex_mem_re & (ex_rd != '0) & id_valid
                      & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    always_comb begin
        fwd_a = pick_src(ex_rs1, mem_src_ok, mem_rd, wb_src_ok, wb_rd);
        fwd_b = pick_src(ex_rs2, mem_src_ok, mem_rd, wb_src_ok, wb_rd);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - EX/MEM/WB control sequencer with stall/flush/forwarding; PIPE_CTRL_PERF_EN adds stall/flush counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = CPU_REG_ADDR_W,
    parameter int PERF_CNT_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_id_valid,
    input  cpu_ctrl_t             i_id_ctrl,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_ex_redirect,
    input  logic                  i_mem_ready,
    output logic                  o_stall,
    output logic                  o_flush,
    output logic                  o_ex_valid,
    output logic [Q3_W-1:0]       o_ex_q3,
    output logic                  o_mem_valid,
    output logic [2:0]            o_mem_q4,
    output logic                  o_wb_valid,
    output logic [1:0]            o_wb_q5,
    output logic [REG_ADDR_W-1:0] o_wb_rd,
    output fwd_sel_t              o_fwd_a,
    output fwd_sel_t              o_fwd_b,
    output logic [PERF_CNT_W-1:0] o_perf_stall,
    output logic [PERF_CNT_W-1:0] o_perf_flush
);

    typedef struct packed {
        logic                  valid;
        cpu_ctrl_t             ctrl;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
    } stage_t;

    stage_t   ex_q;
    stage_t   mem_q;
    stage_t   wb_q;
    stage_t   id_stage;
    logic     freeze;
    logic     redirect;
    logic     load_use;
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;
    logic     unused_bits;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .id_valid          (i_id_valid),
        .id_rs1            (i_id_rs1),
        .id_rs2            (i_id_rs2),
        .ex_redirect       (i_ex_redirect),
        .mem_ready         (i_mem_ready),
        .ex_valid          (ex_q.valid),
        .ex_mem_re         (ex_q.ctrl.mem_re),
        .ex_rd             (ex_q.rd),
        .ex_rs1            (ex_q.rs1),
        .ex_rs2            (ex_q.rs2),
        .mem_valid         (mem_q.valid),
        .mem_re            (mem_q.ctrl.mem_re),
        .mem_we            (mem_q.ctrl.mem_we),
        .mem_reg_wr_en     (mem_q.ctrl.reg_wr_en),
        .mem_is_mem_to_reg (mem_q.ctrl.is_mem_to_reg),
        .mem_rd            (mem_q.rd),
        .wb_valid          (wb_q.valid),
        .wb_reg_wr_en      (wb_q.ctrl.reg_wr_en),
        .wb_rd             (wb_q.rd),
        .freeze            (freeze),
        .redirect          (redirect),
        .load_use          (load_use),
        .fwd_a             (fwd_a),
        .fwd_b             (fwd_b)
    );

    // An invalid ID slot enters EX as a clean bubble so stale control never leaks downstream.
    always_comb begin
        id_stage = '0;
        if (i_id_valid) begin
            id_stage.valid = 1'b1;
            id_stage.ctrl  = i_id_ctrl;
            id_stage.rd    = i_id_rd;
            id_stage.rs1   = i_id_rs1;
            id_stage.rs2   = i_id_rs2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (freeze) begin
            wb_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= (redirect || load_use) ? '0 : id_stage;
        end
    end

    // Freeze outranks redirect; a redirect seen during a freeze is re-evaluated once the pipe moves.
    assign o_stall = ~i_rst & (freeze | (load_use & ~redirect));
    assign o_flush = ~i_rst & ~freeze & redirect;

    assign o_ex_valid  = ex_q.valid;
    assign o_ex_q3     = {ex_q.ctrl.aluop, ex_q.ctrl.alusrc};
    assign o_mem_valid = mem_q.valid;
    assign o_mem_q4    = mem_q.valid ? {mem_q.ctrl.is_branch, mem_q.ctrl.mem_re, mem_q.ctrl.mem_we} : 3'b000;
    assign o_wb_valid  = wb_q.valid;
    assign o_wb_q5     = wb_q.valid ? {wb_q.ctrl.reg_wr_en, wb_q.ctrl.is_mem_to_reg} : 2'b00;
    assign o_wb_rd     = wb_q.rd;
    assign o_fwd_a     = fwd_a;
    assign o_fwd_b     = fwd_b;

    assign unused_bits = ^{ex_q, mem_q, wb_q};

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_CNT_W-1:0] perf_stall_q;
    logic [PERF_CNT_W-1:0] perf_flush_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (o_stall)
                perf_stall_q <= perf_stall_q + 1'b1;
            if (o_flush)
                perf_flush_q <= perf_flush_q + 1'b1;
        end
    end

    assign o_perf_stall = perf_stall_q;
    assign o_perf_flush = perf_flush_q;
`else
    assign o_perf_stall = '0;
    assign o_perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed vector table plus randomized reference-model run for pipe_ctrl
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int RW = 5;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    cpu_ctrl_t     id_ctrl;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          ex_redirect, mem_ready;
    logic          stall, flush, ex_valid, mem_valid, wb_valid;
    logic [Q3_W-1:0] ex_q3;
    logic [2:0]    mem_q4;
    logic [1:0]    wb_q5;
    logic [RW-1:0] wb_rd;
    fwd_sel_t      fwd_a, fwd_b;
    logic [PW-1:0] perf_stall, perf_flush;

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_ADDR_W(RW), .PERF_CNT_W(PW)) dut (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_ctrl(id_ctrl),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
        .i_ex_redirect(ex_redirect), .i_mem_ready(mem_ready),
        .o_stall(stall), .o_flush(flush), .o_ex_valid(ex_valid), .o_ex_q3(ex_q3),
        .o_mem_valid(mem_valid), .o_mem_q4(mem_q4), .o_wb_valid(wb_valid), .o_wb_q5(wb_q5),
        .o_wb_rd(wb_rd), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
        .o_perf_stall(perf_stall), .o_perf_flush(perf_flush)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic      idv;
        cpu_ctrl_t ctrl;
        logic [RW-1:0] rs1, rs2, rd;
        logic      redir, ready;
        logic      st, fl;
        fwd_sel_t  fa, fb;
        logic      ev, mv, wv;
    } vec_t;

    vec_t vt[$];
    cpu_ctrl_t c_lw, c_add, c_sub, c_sw, c_beq, c_nop;

    task automatic add(input logic idv, input cpu_ctrl_t c, input int rs1, input int rs2, input int rd,
                       input logic redir, input logic ready, input logic st, input logic fl,
                       input fwd_sel_t fa, input fwd_sel_t fb, input logic ev, input logic mv, input logic wv);
        vec_t v;
        v.idv = idv; v.ctrl = c; v.rs1 = RW'(rs1); v.rs2 = RW'(rs2); v.rd = RW'(rd);
        v.redir = redir; v.ready = ready; v.st = st; v.fl = fl; v.fa = fa; v.fb = fb;
        v.ev = ev; v.mv = mv; v.wv = wv;
        vt.push_back(v);
    endtask

    task automatic nop(input logic ev, input logic mv, input logic wv);
        add(1'b0, c_nop, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, FWD_NONE, FWD_NONE, ev, mv, wv);
    endtask

    task automatic drive(input logic idv, input cpu_ctrl_t c, input logic [RW-1:0] rs1,
                         input logic [RW-1:0] rs2, input logic [RW-1:0] rd,
                         input logic redir, input logic ready);
        id_valid = idv; id_ctrl = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        ex_redirect = redir; mem_ready = ready;
    endtask

    task automatic run_vec(input int i);
        @(negedge clk);
        drive(vt[i].idv, vt[i].ctrl, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].redir, vt[i].ready);
        #1;
        chk($sformatf("v%0d stall", i), 32'(stall), 32'(vt[i].st));
        chk($sformatf("v%0d flush", i), 32'(flush), 32'(vt[i].fl));
        chk($sformatf("v%0d fwd_a", i), 32'(fwd_a), 32'(vt[i].fa));
        chk($sformatf("v%0d fwd_b", i), 32'(fwd_b), 32'(vt[i].fb));
        chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(vt[i].ev));
        chk($sformatf("v%0d mem_valid", i), 32'(mem_valid), 32'(vt[i].mv));
        chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(vt[i].wv));
    endtask

    task automatic check_perf(input string name, input int exp_st, input int exp_fl);
`ifdef PIPE_CTRL_PERF_EN
        chk({name, " perf_stall"}, 32'(perf_stall), 32'(exp_st));
        chk({name, " perf_flush"}, 32'(perf_flush), 32'(exp_fl));
`else
        chk({name, " perf_stall"}, 32'(perf_stall), 32'(exp_st * 0));
        chk({name, " perf_flush"}, 32'(perf_flush), 32'(exp_fl * 0));
`endif
    endtask

    task automatic check_idle(input string name);
        chk({name, " stall"}, 32'(stall), 0);
        chk({name, " flush"}, 32'(flush), 0);
        chk({name, " valids"}, 32'({ex_valid, mem_valid, wb_valid}), 0);
        chk({name, " fwd"}, 32'({fwd_a, fwd_b}), 0);
        chk({name, " q3q4q5"}, 32'({ex_q3, mem_q4, wb_q5}), 0);
        chk({name, " wb_rd"}, 32'(wb_rd), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, c_nop, '0, '0, '0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: pipeline as an array of slots, index 0=EX, 1=MEM, 2=WB.
    typedef struct {
        logic      v;
        cpu_ctrl_t c;
        logic [RW-1:0] rd, rs1, rs2;
    } slot_t;

    slot_t pipe[3];
    int unsigned m_stall, m_flush;

    function automatic fwd_sel_t model_fwd(input logic [RW-1:0] rs);
        if (rs == 0) return FWD_NONE;
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].v && pipe[k].c.reg_wr_en && pipe[k].rd == rs
                && !(k == 1 && pipe[k].c.is_mem_to_reg))
                return (k == 1) ? FWD_MEM : FWD_WB;
        end
        return FWD_NONE;
    endfunction

    int s3_lo, s3_hi, s5_lo;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        c_nop = '0;
        c_lw  = '0; c_lw.alusrc = 1; c_lw.mem_re = 1; c_lw.reg_wr_en = 1; c_lw.is_mem_to_reg = 1;
        c_add = '0; c_add.reg_wr_en = 1;
        c_sub = '0; c_sub.aluop = 4'd1; c_sub.reg_wr_en = 1;
        c_sw  = '0; c_sw.alusrc = 1; c_sw.mem_we = 1;
        c_beq = '0; c_beq.aluop = 4'd1; c_beq.is_branch = 1;

        // load-use then forward from WB
        add(1, c_lw,  1, 0, 5, 0, 1, 0, 0, FWD_NONE, FWD_NONE, 0, 0, 0);
        add(1, c_add, 5, 1, 6, 0, 1, 1, 0, FWD_NONE, FWD_NONE, 1, 0, 0);
        add(1, c_add, 5, 1, 6, 0, 1, 0, 0, FWD_NONE, FWD_NONE, 0, 1, 0);
        add(0, c_nop, 0, 0, 0, 0, 1, 0, 0, FWD_WB,   FWD_NONE, 1, 0, 1);
        nop(0, 1, 0);
        // ALU-ALU forward from MEM, then rd=x0 variant
        add(1, c_add, 1, 2, 3, 0, 1, 0, 0, FWD_NONE, FWD_NONE, 0, 0, 1);
        add(1, c_sub, 3, 3, 4, 0, 1, 0, 0, FWD_NONE, FWD_NONE, 1, 0, 0);
        add(0, c_nop, 0, 0, 0, 0, 1, 0, 0, FWD_MEM,  FWD_MEM,  1, 1, 0);
        nop(0, 1, 1);
        add(1, c_add, 1, 2, 0, 0, 1, 0, 0, FWD_NONE, FWD_NONE, 0, 0, 1);
        add(1, c_sub, 0, 0, 4, 0, 1, 0, 0, FWD_NONE, FWD_NONE, 1, 0, 0);
        nop(1, 1, 0);
        nop(0, 1, 1);
        nop(0, 0, 1);
        nop(0, 0, 0);
        // store held in MEM for three cycles
        s3_lo = vt.size();
        add(1, c_sw,  1, 2, 0, 0, 1, 0, 0, FWD_NONE, FWD_NONE, 0, 0, 0);
        add(1, c_add, 1, 2, 7, 0, 1, 0, 0, FWD_NONE, FWD_NONE, 1, 0, 0);
        add(1, c_add, 9, 9, 8, 0, 0, 1, 0, FWD_NONE, FWD_NONE, 1, 1, 0);
        add(1, c_add, 9, 9, 8, 0, 0, 1, 0, FWD_NONE, FWD_NONE, 1, 1, 0);
        add(1, c_add, 9, 9, 8, 0, 0, 1, 0, FWD_NONE, FWD_NONE, 1, 1, 0);
        add(1, c_add, 9, 9, 8, 0, 1, 0, 0, FWD_NONE, FWD_NONE, 1, 1, 0);
        nop(1, 1, 1);
        nop(0, 1, 1);
        nop(0, 0, 1);
        nop(0, 0, 0);
        s3_hi = vt.size() - 1;
        // redirect wins over load-use in the same cycle
        add(1, c_lw,  1, 0, 5, 0, 1, 0, 0, FWD_NONE, FWD_NONE, 0, 0, 0);
        add(1, c_add, 5, 1, 6, 1, 1, 0, 1, FWD_NONE, FWD_NONE, 1, 0, 0);
        nop(0, 1, 0);
        nop(0, 0, 1);
        nop(0, 0, 0);
        // redirect held back by a freeze, then one flush
        s5_lo = vt.size();
        add(1, c_sw,  1, 2, 0, 0, 1, 0, 0, FWD_NONE, FWD_NONE, 0, 0, 0);
        add(1, c_beq, 1, 2, 0, 0, 1, 0, 0, FWD_NONE, FWD_NONE, 1, 0, 0);
        add(1, c_add, 1, 2, 9, 1, 0, 1, 0, FWD_NONE, FWD_NONE, 1, 1, 0);
        add(1, c_add, 1, 2, 9, 1, 0, 1, 0, FWD_NONE, FWD_NONE, 1, 1, 0);
        add(1, c_add, 1, 2, 9, 1, 1, 0, 1, FWD_NONE, FWD_NONE, 1, 1, 0);
        nop(0, 1, 1);
        nop(0, 0, 1);
        nop(0, 0, 0);

        rst = 1'b1;
        drive(1'b0, c_nop, '0, '0, '0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("reset");
        check_perf("reset", 0, 0);

        for (int i = 0; i < vt.size(); i++)
            run_vec(i);
        check_perf("table", 6, 2);

        do_reset();
        for (int i = s3_lo; i <= s3_hi; i++)
            run_vec(i);
        check_perf("store_wait", 3, 0);

        // reset while frozen
        for (int i = s5_lo; i < s5_lo + 3; i++)
            run_vec(i);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, c_add, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
        #1;
        chk("rst_freeze stall", 32'(stall), 0);
        chk("rst_freeze flush", 32'(flush), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, c_nop, '0, '0, '0, 1'b0, 1'b0);
        #1;
        check_idle("after_rst");
        check_perf("after_rst", 0, 0);

        // randomized run against the slot-array model
        do_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{default: '0};
        m_stall = 0;
        m_flush = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic r_rst, r_idv, r_red, r_rdy, frz, red, lu, e_st, e_fl;
            cpu_ctrl_t r_c;
            logic [RW-1:0] r_rs1, r_rs2, r_rd;
            r_rst = ($urandom_range(0, 63) == 0);
            r_idv = ($urandom_range(0, 3) != 0);
            r_c   = cpu_ctrl_t'($urandom_range(0, 1023));
            r_rs1 = RW'($urandom_range(0, 3));
            r_rs2 = RW'($urandom_range(0, 3));
            r_rd  = RW'($urandom_range(0, 3));
            r_red = ($urandom_range(0, 7) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            rst = r_rst;
            drive(r_idv, r_c, r_rs1, r_rs2, r_rd, r_red, r_rdy);
            #1;
            frz  = pipe[1].v && (pipe[1].c.mem_re || pipe[1].c.mem_we) && !r_rdy;
            red  = pipe[0].v && r_red;
            lu   = pipe[0].v && pipe[0].c.mem_re && pipe[0].rd != 0 && r_idv
                   && (pipe[0].rd == r_rs1 || pipe[0].rd == r_rs2);
            e_st = !r_rst && (frz || (lu && !red));
            e_fl = !r_rst && !frz && red;
            chk("rnd stall", 32'(stall), 32'(e_st));
            chk("rnd flush", 32'(flush), 32'(e_fl));
            chk("rnd fwd_a", 32'(fwd_a), 32'(model_fwd(pipe[0].rs1)));
            chk("rnd fwd_b", 32'(fwd_b), 32'(model_fwd(pipe[0].rs2)));
            chk("rnd valids", 32'({ex_valid, mem_valid, wb_valid}), 32'({pipe[0].v, pipe[1].v, pipe[2].v}));
            chk("rnd q3", 32'(ex_q3), 32'({pipe[0].c.aluop, pipe[0].c.alusrc}));
            chk("rnd q4", 32'(mem_q4),
                pipe[1].v ? 32'({pipe[1].c.is_branch, pipe[1].c.mem_re, pipe[1].c.mem_we}) : 32'(0));
            chk("rnd q5", 32'(wb_q5),
                pipe[2].v ? 32'({pipe[2].c.reg_wr_en, pipe[2].c.is_mem_to_reg}) : 32'(0));
            chk("rnd wb_rd", 32'(wb_rd), 32'(pipe[2].rd));
            if (r_rst) begin
                for (int k = 0; k < 3; k++) pipe[k] = '{default: '0};
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (e_st) m_stall++;
                if (e_fl) m_flush++;
                if (frz) begin
                    pipe[2] = '{default: '0};
                end else begin
                    pipe[2] = pipe[1];
                    pipe[1] = pipe[0];
                    if (red || lu || !r_idv)
                        pipe[0] = '{default: '0};
                    else
                        pipe[0] = '{v: 1'b1, c: r_c, rd: r_rd, rs1: r_rs1, rs2: r_rs2};
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, c_nop, '0, '0, '0, 1'b0, 1'b1);
        #1;
        check_perf("random", int'(m_stall), int'(m_flush));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
